td4_regfile: RTL and testbench
==============================

# td4_regfile

Parametrised architectural state block for the TD4-class CPU. It holds NREGS general registers of WIDTH bits, a program counter with increment and load, and a clocked carry flag with its negative-logic jump view. It sits between the decoder/ALU and the instruction ROM, and replaces separate per-register modules with one bank that has uniform enable, write-select and flag semantics. All state is clocked, including the flag.

## Interface
Parameters:
- WIDTH, 4: data width of general registers and write data.
- NREGS, 2: number of general registers, 2..16; index 0 = A, 1 = B.
- PC_WIDTH, 4: program counter width; ROM depth is 2**PC_WIDTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset; synchronous, active-high.
- EN  in  1  clock enable; 0 freezes all state.
- WE  in  1  general-register write strobe.
- WADDR  in  $clog2(NREGS)  write register index.
- WDATA  in  WIDTH  write data (ALU result).
- RADDR_A / RADDR_B  in  $clog2(NREGS)  read indices.
- RDATA_A / RDATA_B  out  WIDTH  combinational read data.
- PC_LOAD  in  1  jump: load PC_DATA instead of incrementing.
- PC_DATA  in  PC_WIDTH  jump target (immediate).
- FLAG_WE  in  1  update flags this cycle.
- CARRY_IN  in  1  ALU carry out.
- PC_OUT  out  PC_WIDTH  current program counter.
- CARRY_OUT  out  1  registered carry.
- NCARRY_OUT  out  1  ~CARRY_OUT, for JNC.
- ZERO_OUT  out  1  registered zero flag (only with TD4_ZERO_FLAG_EN).

## Operation
- Reset (CLR=1 at an edge): all registers 0, PC 0, CARRY 0, ZERO 0. So NCARRY_OUT=1. Reset overrides EN and all other inputs.
- EN=0: no state changes. Outputs hold, and PC does not count.
- EN=1, per edge. All updates are independent and concurrent:
  - General register: if WE and WADDR<NREGS, reg[WADDR] <= WDATA. Out-of-range WADDR (NREGS not a power of 2) is ignored.
  - PC: if PC_LOAD, PC <= PC_DATA. Otherwise PC <= PC+1, wrapping from 2**PC_WIDTH-1 to 0. No carry out.
  - Flags: if FLAG_WE, CARRY <= CARRY_IN. Otherwise hold. The flag is not cleared by non-ALU instructions unless FLAG_WE is set.
- Reads are combinational from current state. Out-of-range RADDR returns 0.
- Write and read to the same index in the same cycle: RDATA shows the old value until after the edge. There is no bypass.
- PC_LOAD and a register write in the same cycle are both performed.
- WIDTH and PC_WIDTH are independent. PC_DATA is a separate port, and the decoder truncates/extends the immediate.

## Timing
- Write-to-read latency: 1 cycle (value visible on RDATA right after the capturing edge).
- PC_OUT changes only on a rising edge with EN=1 or CLR=1. There are no combinational paths from inputs to PC_OUT, CARRY_OUT or ZERO_OUT.
- Combinational paths exist only from RADDR_* to RDATA_*.
- Reset mid-operation: a pending PC_LOAD, WE or FLAG_WE in the reset cycle is discarded.
- First instruction fetch after reset deasserts is at PC=0.

## Configuration
- TD4_ZERO_FLAG_EN defined:
  - ZERO_OUT port exists.
  - With FLAG_WE, ZERO <= (WDATA == 0), captured on the same edge as CARRY. Reset value 0.
- Undefined: no ZERO_OUT port and no zero-flag register. Behaviour is otherwise identical.

## Structure
- Shared package td4_pkg holds:
  - default widths (TD4_WIDTH=4, TD4_PC_WIDTH=4, TD4_NREGS=2);
  - register index constants REG_A=0, REG_B=1;
  - the flag-bundle typedef (carry, zero).
- Sub-module td4_pc holds the program counter (load/increment/wrap, EN, CLR). It is instantiated once; the register array and flags stay in the top.

## Test plan
- Reset: drive CLR=1 for 1 cycle with WE=1, WDATA=0xF, PC_LOAD=1 -> next cycle all regs 0, PC_OUT=0, CARRY_OUT=0, NCARRY_OUT=1.
- Count and wrap: EN=1, no loads, 17 edges from reset (PC_WIDTH=4) -> PC_OUT goes 1..15, 0, 1. With EN=0 for 3 edges -> PC unchanged.
- Jump: PC=5, PC_LOAD=1, PC_DATA=0xC -> PC_OUT=0xC next cycle; the following edge gives 0xD.
- Write/read: WE=1, WADDR=1, WDATA=0x7, RADDR_A=1 -> RDATA_A shows old value before the edge and 0x7 after. WADDR=0 write leaves reg 1 unchanged.
- Flags: FLAG_WE=1, CARRY_IN=1 -> CARRY_OUT=1, NCARRY_OUT=0. Next cycle FLAG_WE=0, CARRY_IN=0 -> CARRY_OUT stays 1. With TD4_ZERO_FLAG_EN and WDATA=0 -> ZERO_OUT=1.
- Parametrised build: WIDTH=8, NREGS=4. Write 0xA5 to reg 3 and 0x3C to reg 2 -> RDATA_A/RDATA_B on indices 3/2 read 0xA5/0x3C, regs 0 and 1 remain 0.

Source files
------------

// File: rtl/td4_regfile_pkg.sv
// td4_pkg: shared definitions for the TD4 architectural state block.
//   - default widths (data, PC, register count)
//   - register index constants (A, B)
//   - flag bundle typedef (carry, zero)
//   - td4_aw(): index width for a register count (at least 1 bit)
package td4_pkg;

    localparam int TD4_WIDTH    = 4;
    localparam int TD4_PC_WIDTH = 4;
    localparam int TD4_NREGS    = 2;

    localparam int REG_A = 0;
    localparam int REG_B = 1;

    typedef struct packed {
        logic carry;
        logic zero;
    } td4_flags_t;

    function automatic int td4_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/td4_regfile_if.sv
// td4_regfile_if: decoder/ALU <-> register bank bus.
//   master: EN, WE, WADDR, WDATA, RADDR_A/B, PC_LOAD, PC_DATA, FLAG_WE, CARRY_IN out;
//           RDATA_A/B, PC_OUT, CARRY_OUT, NCARRY_OUT (ZERO_OUT) in.
//   slave : the mirror image.
// Optional macro TD4_ZERO_FLAG_EN adds ZERO_OUT.
interface td4_regfile_if
    import td4_pkg::*;
#(
    parameter int WIDTH    = TD4_WIDTH,
    parameter int NREGS    = TD4_NREGS,
    parameter int PC_WIDTH = TD4_PC_WIDTH
);
    localparam int AW = td4_aw(NREGS);

    logic                EN;
    logic                WE;
    logic [AW-1:0]       WADDR;
    logic [WIDTH-1:0]    WDATA;
    logic [AW-1:0]       RADDR_A;
    logic [AW-1:0]       RADDR_B;
    logic [WIDTH-1:0]    RDATA_A;
    logic [WIDTH-1:0]    RDATA_B;
    logic                PC_LOAD;
    logic [PC_WIDTH-1:0] PC_DATA;
    logic                FLAG_WE;
    logic                CARRY_IN;
    logic [PC_WIDTH-1:0] PC_OUT;
    logic                CARRY_OUT;
    logic                NCARRY_OUT;
`ifdef TD4_ZERO_FLAG_EN
    logic                ZERO_OUT;
`endif

    modport master (
        output EN, WE, WADDR, WDATA, RADDR_A, RADDR_B, PC_LOAD, PC_DATA, FLAG_WE, CARRY_IN,
        input  RDATA_A, RDATA_B, PC_OUT, CARRY_OUT, NCARRY_OUT
`ifdef TD4_ZERO_FLAG_EN
        , input ZERO_OUT
`endif
    );

    modport slave (
        input  EN, WE, WADDR, WDATA, RADDR_A, RADDR_B, PC_LOAD, PC_DATA, FLAG_WE, CARRY_IN,
        output RDATA_A, RDATA_B, PC_OUT, CARRY_OUT, NCARRY_OUT
`ifdef TD4_ZERO_FLAG_EN
        , output ZERO_OUT
`endif
    );

endinterface

// File: rtl/td4_regfile_pc.sv
// td4_pc: program counter.
//   clk/clr : clock, synchronous active-high clear
//   en      : clock enable, 0 holds the count
//   load    : take data instead of incrementing
//   data    : jump target
//   pc      : registered program counter (wraps modulo 2**PC_WIDTH)
module td4_pc #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] data,
    output logic [PC_WIDTH-1:0] pc
);
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = load ? data : pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) pc_q <= '0;
        else     pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/td4_regfile.sv
// td4_regfile: TD4 architectural state (general registers, PC, carry/zero flags).
//   CLK, CLR : clock, synchronous active-high reset (overrides everything)
//   bus      : td4_regfile_if.slave -- write port, two combinational read ports,
//              PC load/increment, flag update, registered PC and flag outputs.
// Optional macro TD4_ZERO_FLAG_EN adds the zero flag register and ZERO_OUT.
module td4_regfile
    import td4_pkg::*;
#(
    parameter int WIDTH    = TD4_WIDTH,
    parameter int NREGS    = TD4_NREGS,
    parameter int PC_WIDTH = TD4_PC_WIDTH
) (
    input  logic          CLK,
    input  logic          CLR,
    td4_regfile_if.slave  bus
);
    localparam int        AW      = td4_aw(NREGS);
    // Index range check is done one bit wider so NREGS == 2**AW compares cleanly.
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                        carry_w;

    always_comb begin
        regs_d = regs_q;
        if (bus.EN && bus.WE && ({1'b0, bus.WADDR} < NREGS_W)) begin
            regs_d[bus.WADDR] = bus.WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    // No bypass: reads always see the pre-edge contents.
    assign bus.RDATA_A = ({1'b0, bus.RADDR_A} < NREGS_W) ? regs_q[bus.RADDR_A] : '0;
    assign bus.RDATA_B = ({1'b0, bus.RADDR_B} < NREGS_W) ? regs_q[bus.RADDR_B] : '0;

`ifdef TD4_ZERO_FLAG_EN
    td4_flags_t flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (bus.EN && bus.FLAG_WE) begin
            flags_d.carry = bus.CARRY_IN;
            flags_d.zero  = (bus.WDATA == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) flags_q <= '0;
        else     flags_q <= flags_d;
    end

    assign carry_w      = flags_q.carry;
    assign bus.ZERO_OUT = flags_q.zero;
`else
    logic carry_q, carry_d;

    always_comb begin
        carry_d = carry_q;
        if (bus.EN && bus.FLAG_WE) carry_d = bus.CARRY_IN;
    end

    always_ff @(posedge CLK) begin
        if (CLR) carry_q <= 1'b0;
        else     carry_q <= carry_d;
    end

    assign carry_w = carry_q;
`endif

    assign bus.CARRY_OUT  = carry_w;
    assign bus.NCARRY_OUT = ~carry_w;

    td4_pc #(.PC_WIDTH(PC_WIDTH)) u_pc (
        .clk  (CLK),
        .clr  (CLR),
        .en   (bus.EN),
        .load (bus.PC_LOAD),
        .data (bus.PC_DATA),
        .pc   (bus.PC_OUT)
    );

endmodule

// File: tb/tb_td4_regfile.sv
// Bench for td4_regfile: three builds share one stimulus stream
//   0: WIDTH=4 NREGS=2 PC_WIDTH=4 (default), 1: WIDTH=8 NREGS=4 PC_WIDTH=4,
//   2: WIDTH=4 NREGS=3 PC_WIDTH=3 (non power-of-2 register count).
module tb_td4_regfile;
    import td4_pkg::*;

    logic       clk = 1'b0;
    logic       clr, en, we, pc_load, flag_we, carry_in;
    logic [1:0] waddr, ra, rb;
    logic [7:0] wdata;
    logic [3:0] pcdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    td4_regfile_if #(.WIDTH(4), .NREGS(2), .PC_WIDTH(4)) b0 ();
    td4_regfile_if #(.WIDTH(8), .NREGS(4), .PC_WIDTH(4)) b1 ();
    td4_regfile_if #(.WIDTH(4), .NREGS(3), .PC_WIDTH(3)) b2 ();

    td4_regfile #(.WIDTH(4), .NREGS(2), .PC_WIDTH(4)) dut0 (.CLK(clk), .CLR(clr), .bus(b0));
    td4_regfile #(.WIDTH(8), .NREGS(4), .PC_WIDTH(4)) dut1 (.CLK(clk), .CLR(clr), .bus(b1));
    td4_regfile #(.WIDTH(4), .NREGS(3), .PC_WIDTH(3)) dut2 (.CLK(clk), .CLR(clr), .bus(b2));

    assign b0.EN = en;  assign b1.EN = en;  assign b2.EN = en;
    assign b0.WE = we;  assign b1.WE = we;  assign b2.WE = we;
    assign b0.PC_LOAD = pc_load;   assign b1.PC_LOAD = pc_load;   assign b2.PC_LOAD = pc_load;
    assign b0.FLAG_WE = flag_we;   assign b1.FLAG_WE = flag_we;   assign b2.FLAG_WE = flag_we;
    assign b0.CARRY_IN = carry_in; assign b1.CARRY_IN = carry_in; assign b2.CARRY_IN = carry_in;
    assign b0.WADDR = waddr[0];    assign b1.WADDR = waddr;       assign b2.WADDR = waddr;
    assign b0.RADDR_A = ra[0];     assign b1.RADDR_A = ra;        assign b2.RADDR_A = ra;
    assign b0.RADDR_B = rb[0];     assign b1.RADDR_B = rb;        assign b2.RADDR_B = rb;
    assign b0.WDATA = wdata[3:0];  assign b1.WDATA = wdata;       assign b2.WDATA = wdata[3:0];
    assign b0.PC_DATA = pcdata;    assign b1.PC_DATA = pcdata;    assign b2.PC_DATA = pcdata[2:0];

    // Observed outputs, flattened per build.
    int o_ra[3], o_rb[3], o_pc[3], o_c[3], o_nc[3], o_z[3];
    always_comb begin
        o_ra[0] = int'(b0.RDATA_A); o_ra[1] = int'(b1.RDATA_A); o_ra[2] = int'(b2.RDATA_A);
        o_rb[0] = int'(b0.RDATA_B); o_rb[1] = int'(b1.RDATA_B); o_rb[2] = int'(b2.RDATA_B);
        o_pc[0] = int'(b0.PC_OUT);  o_pc[1] = int'(b1.PC_OUT);  o_pc[2] = int'(b2.PC_OUT);
        o_c[0]  = int'(b0.CARRY_OUT);  o_c[1]  = int'(b1.CARRY_OUT);  o_c[2]  = int'(b2.CARRY_OUT);
        o_nc[0] = int'(b0.NCARRY_OUT); o_nc[1] = int'(b1.NCARRY_OUT); o_nc[2] = int'(b2.NCARRY_OUT);
`ifdef TD4_ZERO_FLAG_EN
        o_z[0] = int'(b0.ZERO_OUT); o_z[1] = int'(b1.ZERO_OUT); o_z[2] = int'(b2.ZERO_OUT);
`else
        o_z[0] = 0; o_z[1] = 0; o_z[2] = 0;
`endif
    end

    // Reference model: architectural state as plain integers.
    int mw[3] = '{4, 8, 4};   // data width
    int mn[3] = '{2, 4, 3};   // register count
    int ma[3] = '{1, 2, 2};   // index width
    int mp[3] = '{4, 4, 3};   // PC width
    int m_reg[3][4];
    int m_pc[3], m_c[3], m_z[3];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int wa = int'(waddr) % (1 << ma[i]);
            int wd = int'(wdata) % (1 << mw[i]);
            if (clr) begin
                for (int j = 0; j < 4; j++) m_reg[i][j] = 0;
                m_pc[i] = 0; m_c[i] = 0; m_z[i] = 0;
            end else if (en) begin
                if (we && wa < mn[i]) m_reg[i][wa] = wd;
                m_pc[i] = pc_load ? int'(pcdata) % (1 << mp[i]) : (m_pc[i] + 1) % (1 << mp[i]);
                if (flag_we) begin
                    m_c[i] = int'(carry_in);
                    m_z[i] = (wd == 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int ia = int'(ra) % (1 << ma[i]);
            int ib = int'(rb) % (1 << ma[i]);
            chk($sformatf("rdata_a[%0d]", i), o_ra[i], (ia < mn[i]) ? m_reg[i][ia] : 0);
            chk($sformatf("rdata_b[%0d]", i), o_rb[i], (ib < mn[i]) ? m_reg[i][ib] : 0);
            chk($sformatf("pc[%0d]", i), o_pc[i], m_pc[i]);
            chk($sformatf("carry[%0d]", i), o_c[i], m_c[i]);
            chk($sformatf("ncarry[%0d]", i), o_nc[i], 1 - m_c[i]);
`ifdef TD4_ZERO_FLAG_EN
            chk($sformatf("zero[%0d]", i), o_z[i], m_z[i]);
`endif
        end
    endtask

    // Check pre-edge state mid-cycle, then clock and advance the model.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        clr = 1'b0; en = 1'b1; we = 1'b0; pc_load = 1'b0; flag_we = 1'b0; carry_in = 1'b0;
    endtask

    initial begin
        // Reset with every write path asserted: all of it must be discarded.
        clr = 1'b1; en = 1'b1; we = 1'b1; waddr = 2'd0; wdata = 8'h0F;
        pc_load = 1'b1; pcdata = 4'hC; flag_we = 1'b1; carry_in = 1'b1;
        ra = 2'(REG_A); rb = 2'(REG_B);
        @(posedge clk); model_edge(); #1;
        chk("rst_pc", o_pc[0], 0);
        chk("rst_carry", o_c[0], 0);
        chk("rst_ncarry", o_nc[0], 1);
        chk("rst_reg_a", o_ra[0], 0);
        chk("rst_reg_b", o_rb[0], 0);
        quiet();

        // Count and wrap, then freeze.
        repeat (17) cycle();
        chk("wrap_pc", o_pc[0], 1);
        en = 1'b0;
        repeat (3) cycle();
        chk("hold_pc", o_pc[0], 1);

        // Jump from 5 to 0xC, then increment.
        en = 1'b1;
        repeat (4) cycle();
        chk("pre_jump_pc", o_pc[0], 5);
        pc_load = 1'b1; pcdata = 4'hC;
        cycle();
        chk("jump_pc", o_pc[0], 'hC);
        pc_load = 1'b0;
        cycle();
        chk("post_jump_pc", o_pc[0], 'hD);

        // Write/read with no bypass, then write the other register.
        we = 1'b1; waddr = 2'd1; wdata = 8'h07; ra = 2'd1; rb = 2'd0;
        #1 chk("rd_before_edge", o_ra[0], 0);
        cycle();
        chk("rd_after_edge", o_ra[0], 7);
        waddr = 2'd0; wdata = 8'h03;
        cycle();
        chk("reg_b_kept", o_ra[0], 7);
        chk("reg_a_written", o_rb[0], 3);

        // Flags: set carry with zero data, then hold without FLAG_WE.
        we = 1'b0; flag_we = 1'b1; carry_in = 1'b1; wdata = 8'h00;
        cycle();
        chk("carry_set", o_c[0], 1);
        chk("ncarry_clr", o_nc[0], 0);
`ifdef TD4_ZERO_FLAG_EN
        chk("zero_set", o_z[0], 1);
`endif
        flag_we = 1'b0; carry_in = 1'b0;
        cycle();
        chk("carry_hold", o_c[0], 1);

        // Wide build: reset, write regs 3 and 2.
        clr = 1'b1;
        cycle();
        quiet();
        we = 1'b1; waddr = 2'd3; wdata = 8'hA5;
        cycle();
        waddr = 2'd2; wdata = 8'h3C;
        cycle();
        we = 1'b0; ra = 2'd3; rb = 2'd2;
        #1;
        chk("w8_reg3", o_ra[1], 'hA5);
        chk("w8_reg2", o_rb[1], 'h3C);
        chk("n3_oob_read", o_ra[2], 0);
        ra = 2'd0; rb = 2'd1;
        #1;
        chk("w8_reg0", o_ra[1], 0);
        chk("w8_reg1", o_rb[1], 0);

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 400; n++) begin
            clr      = ($urandom_range(0, 31) == 0);
            en       = ($urandom_range(0, 3) != 0);
            we       = 1'($urandom);
            waddr    = 2'($urandom);
            wdata    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ra       = 2'($urandom);
            rb       = 2'($urandom);
            pc_load  = ($urandom_range(0, 3) == 0);
            pcdata   = 4'($urandom);
            flag_we  = 1'($urandom);
            carry_in = 1'($urandom);
            cycle();
        end
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
